// File: rtl/des_pkg.sv
// Constants and types shared by the DES pipeline and its result buffer.
package des_pkg;
  localparam int DES_BLOCK_W      = 64;
  localparam int DES_PIPE_LATENCY = 16;

  typedef logic [DES_BLOCK_W-1:0] des_blk_t;

  typedef enum logic [1:0] {
    FIFO_EMPTY   = 2'd0,
    FIFO_PARTIAL = 2'd1,
    FIFO_FULL    = 2'd2
  } fifo_state_e;
endpackage

// File: rtl/des_rx_buffer_if.sv
// Issue/result/consumer signals of the DES result buffer.
// o_blk_cnt exists only when DES_RXB_STATS_EN is defined.
interface des_rx_buffer_if #(parameter int CNT_W = 6);
  import des_pkg::*;
  logic             i_issue;
  logic             o_issue_ok;
  des_blk_t         i_ct;
  logic             i_ct_dv;
  des_blk_t         o_data;
  logic             o_valid;
  logic             i_ready;
  logic [CNT_W-1:0] o_count;
  logic             o_err;
  logic             i_err_clr;
`ifdef DES_RXB_STATS_EN
  logic [31:0]      o_blk_cnt;
`endif

  modport slave (
    input  i_issue, i_ct, i_ct_dv, i_ready, i_err_clr,
`ifdef DES_RXB_STATS_EN
    output o_blk_cnt,
`endif
    output o_issue_ok, o_data, o_valid, o_count, o_err
  );

  modport master (
    output i_issue, i_ct, i_ct_dv, i_ready, i_err_clr,
`ifdef DES_RXB_STATS_EN
    input  o_blk_cnt,
`endif
    input  o_issue_ok, o_data, o_valid, o_count, o_err
  );
endinterface

// File: rtl/des_rxb_fifo.sv
// Result storage: circular buffer with EMPTY/PARTIAL/FULL control FSM.
// A push into a full buffer is accepted only when a pop happens in the same cycle.
module des_rxb_fifo
  import des_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  des_blk_t         i_wdata,
  input  logic             i_pop,
  output des_blk_t         o_rdata,
  output logic             o_valid,
  output logic             o_push_ok,
  output logic             o_pop_ok,
  output logic [CNT_W-1:0] o_count
);
  localparam int AW = $clog2(DEPTH);

  fifo_state_e      r_state, w_next;
  logic [AW-1:0]    r_wptr, r_rptr;
  logic [CNT_W-1:0] r_count;
  des_blk_t         r_mem [DEPTH];
  logic             w_push, w_pop;

  assign w_pop  = i_pop && (r_state != FIFO_EMPTY);
  assign w_push = i_push && ((r_state != FIFO_FULL) || w_pop);

  always_comb begin
    w_next = r_state;
    case (r_state)
      FIFO_EMPTY:   if (w_push) w_next = FIFO_PARTIAL;
      FIFO_PARTIAL: begin
        if (w_push && !w_pop && r_count == CNT_W'(DEPTH - 1))
          w_next = FIFO_FULL;
        else if (w_pop && !w_push && r_count == CNT_W'(1))
          w_next = FIFO_EMPTY;
      end
      FIFO_FULL:    if (w_pop && !w_push) w_next = FIFO_PARTIAL;
      default:      w_next = FIFO_EMPTY;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= FIFO_EMPTY;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_next;
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (w_pop && !w_push) r_count <= r_count - CNT_W'(1);
    end
  end

  // Storage needs no reset: reads are masked to zero until a word lands.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

  assign o_valid   = (r_state != FIFO_EMPTY);
  assign o_rdata   = o_valid ? r_mem[r_rptr] : '0;
  assign o_push_ok = w_push;
  assign o_pop_ok  = w_pop;
  assign o_count   = r_count;
endmodule

// File: rtl/des_rx_buffer.sv
// Credit-managed receive buffer behind a fixed-latency DES pipeline.
// Define DES_RXB_STATS_EN to add the o_blk_cnt output-transfer counter.
module des_rx_buffer
  import des_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  des_rx_buffer_if.slave     bus
);
  logic [CNT_W-1:0] r_infl;
  logic             r_err;
  logic [CNT_W-1:0] w_count;
  logic             w_push_ok, w_pop_ok;
  logic             w_issue_ok, w_err_evt;

  des_rxb_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_push    (bus.i_ct_dv),
    .i_wdata   (bus.i_ct),
    .i_pop     (bus.i_ready),
    .o_rdata   (bus.o_data),
    .o_valid   (bus.o_valid),
    .o_push_ok (w_push_ok),
    .o_pop_ok  (w_pop_ok),
    .o_count   (w_count)
  );

  // One extra bit: occupancy plus saturated inflight can reach 2*DEPTH.
  assign w_issue_ok = ({1'b0, w_count} + {1'b0, r_infl}) < (CNT_W+1)'(DEPTH);

  assign w_err_evt = (bus.i_issue && !w_issue_ok)
                  || (bus.i_ct_dv && (r_infl == '0))
                  || (bus.i_ct_dv && !w_push_ok);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_infl <= '0;
      r_err  <= 1'b0;
    end else begin
      if (bus.i_issue && !bus.i_ct_dv) begin
        if (r_infl != CNT_W'(DEPTH)) r_infl <= r_infl + CNT_W'(1);
      end else if (bus.i_ct_dv && !bus.i_issue && (r_infl != '0)) begin
        r_infl <= r_infl - CNT_W'(1);
      end
      if (w_err_evt)          r_err <= 1'b1;
      else if (bus.i_err_clr) r_err <= 1'b0;
    end
  end

`ifdef DES_RXB_STATS_EN
  logic [31:0] r_blk_cnt;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)      r_blk_cnt <= '0;
    else if (w_pop_ok) r_blk_cnt <= r_blk_cnt + 32'd1;
  end
  assign bus.o_blk_cnt = r_blk_cnt;
`else
  logic w_unused;
  assign w_unused = w_pop_ok;
`endif

  assign bus.o_issue_ok = w_issue_ok;
  assign bus.o_count    = w_count;
  assign bus.o_err      = r_err;
endmodule

// File: tb/tb_des_rx_buffer.sv
// Directed + random bench for des_rx_buffer against a queue-based reference model.
module tb_des_rx_buffer;
  import des_pkg::*;
  localparam int DEPTH = 32;
  localparam int CNT_W = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  des_rx_buffer_if #(.CNT_W(CNT_W)) bif();
  des_rx_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bif)
  );

  int n_chk = 0;
  int n_err = 0;

  logic [63:0] mq[$];
  int          m_infl;
  bit          m_err;
  int          m_blk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    logic [63:0] ed;
    ed = (mq.size() > 0) ? mq[0] : 64'h0;
    chk({tag, ".valid"},    64'(bif.o_valid),    64'(mq.size() > 0));
    chk({tag, ".data"},     bif.o_data,          ed);
    chk({tag, ".count"},    64'(bif.o_count),    64'(mq.size()));
    chk({tag, ".issue_ok"}, 64'(bif.o_issue_ok), 64'((mq.size() + m_infl) < DEPTH));
    chk({tag, ".err"},      64'(bif.o_err),      64'(m_err));
`ifdef DES_RXB_STATS_EN
    chk({tag, ".blk_cnt"},  64'(bif.o_blk_cnt),  64'(m_blk));
`endif
  endtask

  // Drive one cycle, check state left by previous cycles, then advance the model.
  task automatic cyc(input string tag, input bit issue, input bit dv,
                     input logic [63:0] ct, input bit rdy, input bit clr);
    bit pop, push_ok, ev;
    @(negedge clk);
    bif.i_issue = issue; bif.i_ct_dv = dv; bif.i_ct = ct;
    bif.i_ready = rdy;   bif.i_err_clr = clr;
    #1 chk_all(tag);
    ev      = 1'b0;
    pop     = rdy && (mq.size() > 0);
    push_ok = dv && ((mq.size() < DEPTH) || pop);
    if (issue && !((mq.size() + m_infl) < DEPTH)) ev = 1'b1;
    if (dv && m_infl == 0) ev = 1'b1;
    if (dv && !push_ok)    ev = 1'b1;
    if (pop) begin void'(mq.pop_front()); m_blk++; end
    if (push_ok) mq.push_back(ct);
    if (issue && !dv)                m_infl = (m_infl < DEPTH) ? m_infl + 1 : DEPTH;
    else if (dv && !issue && m_infl > 0) m_infl--;
    if (ev)       m_err = 1'b1;
    else if (clr) m_err = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    #2 rst_n = 1'b0;
    bif.i_issue = 0; bif.i_ct_dv = 0; bif.i_ct = '0; bif.i_ready = 0; bif.i_err_clr = 0;
    mq.delete(); m_infl = 0; m_err = 0; m_blk = 0;
    #1 chk_all(tag);
    chk({tag, ".issue_ok_rst"}, 64'(bif.o_issue_ok), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int pend[$];
    int t, issued;
    bit iss, dv, ok;
    logic [63:0] w;

    bif.i_issue = 0; bif.i_ct_dv = 0; bif.i_ct = '0; bif.i_ready = 0; bif.i_err_clr = 0;
    #3;
    do_reset("rst0");

    // single block through the pipeline latency
    cyc("one_issue", 1, 0, 0, 0, 0);
    repeat (DES_PIPE_LATENCY - 1) cyc("one_wait", 0, 0, 0, 0, 0);
    cyc("one_dv", 0, 1, 64'h85E813540F0AB405, 0, 0);
    cyc("one_out", 0, 0, 0, 1, 0);
    chk("one_out.explicit", bif.o_data, 64'h85E813540F0AB405);
    cyc("one_drained", 0, 0, 0, 1, 0);  // pop on empty has no effect

    // credit exhaustion then over-issue
    repeat (DEPTH) cyc("credit", 1, 0, 0, 0, 0);
    cyc("over_issue", 1, 0, 0, 0, 0);
    cyc("after_over", 0, 0, 0, 0, 1);
    for (int i = 0; i < DEPTH; i++) cyc("fill", 0, 1, {$urandom, $urandom}, 0, 0);
    cyc("full_clr", 0, 0, 0, 0, 1);
    // full FIFO, push and pop together: occupancy holds
    cyc("full_pushpop", 0, 1, {$urandom, $urandom}, 1, 0);
    // overflow drop with clear in same cycle: error stays
    cyc("full_drop_clr", 0, 1, {$urandom, $urandom}, 0, 1);
    cyc("hold_stable", 0, 0, 0, 0, 0);
    for (int i = 0; i < DEPTH + 4 && mq.size() > 0; i++) cyc("drain", 0, 0, 0, 1, 0);
    chk("drain.bound", 64'(mq.size()), 64'd0);

    // unexpected result with nothing in flight
    cyc("unexp_clr", 0, 0, 0, 0, 1);
    cyc("unexp_dv", 0, 1, 64'hDEADBEEF0BADF00D, 0, 0);
    cyc("unexp_clr2", 0, 0, 0, 1, 1);
    cyc("unexp_done", 0, 0, 0, 0, 0);

    // random stream of 100 blocks
    do_reset("rst1");
    t = 0; issued = 0;
    while (m_blk < 100 && t < 3000) begin
      ok  = (mq.size() + m_infl) < DEPTH;
      iss = (issued < 100) && ok && ($urandom_range(0, 3) != 0);
      dv  = (pend.size() > 0) && (pend[0] + DES_PIPE_LATENCY <= t);
      w   = {$urandom, $urandom};
      cyc("stream", iss, dv, w, 1'($urandom_range(0, 1)), 0);
      if (dv) void'(pend.pop_front());
      if (iss) begin pend.push_back(t); issued++; end
      t++;
    end
    cyc("stream_end", 0, 0, 0, 0, 0);
    chk("stream.count", 64'(m_blk), 64'd100);

    // reset with 5 queued and 3 in flight
    repeat (8) cyc("pre_rst_issue", 1, 0, 0, 0, 0);
    repeat (5) cyc("pre_rst_dv", 0, 1, {$urandom, $urandom}, 0, 0);
    do_reset("rst2");
    cyc("post_rst_dv", 0, 1, 64'h0123456789ABCDEF, 0, 0);
    cyc("post_rst_chk", 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
